front_spi_arbiter: RTL and testbench

// - Shares the single Front-panel SPI master between the LCD writer and the switch reader.
// - Sequences each 24-bit transfer: start pulse, wait for n_cs assert/deassert, capture MISO, ack.
// - Routes the master's n_cs to the owner's chip-select. Detects a hung master via a timeout.

---
 rtl/front_spi_arbiter.sv | 150 +++++++++++++++
 tb/tb_front_spi_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/front_spi_arbiter.sv
// rtl/front_spi_arbiter.sv - shares the front-panel SPI master between the LCD writer and the switch reader
// Sequences start/n_cs handshakes, bounds SW streaks while LCD waits, aborts hung transfers.
module front_spi_arbiter #(
  parameter int DATA_W        = 24,
  parameter int TIMEOUT_CYC   = 4096,
  parameter int SW_MAX_STREAK = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lcd_req,
  input  logic [DATA_W-1:0] i_lcd_data,
  output logic              o_lcd_ack,
  input  logic              i_sw_req,
  input  logic [DATA_W-1:0] i_sw_data,
  output logic              o_sw_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_spi_start,
  output logic [DATA_W-1:0] o_mosi_data,
  input  logic              i_spi_cs,
  input  logic [DATA_W-1:0] i_miso_data,
  output logic              o_lcd_cs,
  output logic              o_sw_cs,
  output logic              o_busy,
  output logic              o_timeout_err
);

  localparam int TW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SKW = $clog2(SW_MAX_STREAK + 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [SKW-1:0] STREAK_MAX = SKW'(SW_MAX_STREAK);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_ASSERT, S_WAIT_RELEASE, S_DONE, S_ERR
  } state_t;

  state_t             state_q;
  logic               owner_lcd_q;
  logic               route_q;
  logic [TW-1:0]      timer_q;
  logic [SKW-1:0]     streak_q;
  logic [SKW-1:0]     streak_d;
  logic               start_q;
  logic               lcd_ack_q;
  logic               sw_ack_q;
  logic               err_q;
  logic               busy_q;
  logic [DATA_W-1:0]  mosi_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               grant_sw;
  logic               grant_lcd;

  // SW wins unless LCD has been waiting through a full streak of SW grants.
  assign grant_sw  = i_sw_req && !(i_lcd_req && (streak_q == STREAK_MAX));
  assign grant_lcd = i_lcd_req && !grant_sw;

  always_comb begin
    streak_d = streak_q;
    if (!i_lcd_req || grant_lcd) begin
      streak_d = '0;
    end else if (grant_sw && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      owner_lcd_q <= 1'b0;
      route_q     <= 1'b0;
      timer_q     <= '0;
      streak_q    <= '0;
      start_q     <= 1'b0;
      lcd_ack_q   <= 1'b0;
      sw_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mosi_q      <= '0;
      rdata_q     <= '0;
    end else begin
      start_q   <= 1'b0;
      lcd_ack_q <= 1'b0;
      sw_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          streak_q <= streak_d;
          if (grant_sw || grant_lcd) begin
            owner_lcd_q <= grant_lcd;
            mosi_q      <= grant_lcd ? i_lcd_data : i_sw_data;
            start_q     <= 1'b1;
            busy_q      <= 1'b1;
            route_q     <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT_ASSERT;
        end
        S_WAIT_ASSERT: begin
          if (!i_spi_cs) begin
            timer_q <= '0;
            state_q <= S_WAIT_RELEASE;
          end else if (timer_q == TIMER_LAST) begin
            err_q   <= 1'b1;
            route_q <= 1'b0;
            state_q <= S_ERR;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_WAIT_RELEASE: begin
          if (i_spi_cs) begin
            rdata_q   <= i_miso_data;
            lcd_ack_q <= owner_lcd_q;
            sw_ack_q  <= !owner_lcd_q;
            state_q   <= S_DONE;
          end else if (timer_q == TIMER_LAST) begin
            err_q   <= 1'b1;
            route_q <= 1'b0;
            state_q <= S_ERR;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          busy_q  <= 1'b0;
          route_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          route_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_lcd_cs      = (route_q && owner_lcd_q)  ? i_spi_cs : 1'b1;
  assign o_sw_cs       = (route_q && !owner_lcd_q) ? i_spi_cs : 1'b1;
  assign o_spi_start   = start_q;
  assign o_lcd_ack     = lcd_ack_q;
  assign o_sw_ack      = sw_ack_q;
  assign o_timeout_err = err_q;
  assign o_busy        = busy_q;
  assign o_mosi_data   = mosi_q;
  assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_front_spi_arbiter.sv
// tb/tb_front_spi_arbiter.sv - randomized self-checking bench for front_spi_arbiter
// Behavioural SPI master plus a transaction-level arbitration model.
module tb_front_spi_arbiter;
  localparam int DW   = 24;
  localparam int TO   = 32;
  localparam int SMAX = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_lcd_req = 1'b0;
  logic [DW-1:0] i_lcd_data = '0;
  logic          o_lcd_ack;
  logic          i_sw_req = 1'b0;
  logic [DW-1:0] i_sw_data = '0;
  logic          o_sw_ack;
  logic [DW-1:0] o_rdata;
  logic          o_spi_start;
  logic [DW-1:0] o_mosi_data;
  logic          i_spi_cs = 1'b1;
  logic [DW-1:0] i_miso_data = '0;
  logic          o_lcd_cs;
  logic          o_sw_cs;
  logic          o_busy;
  logic          o_timeout_err;

  front_spi_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TO), .SW_MAX_STREAK(SMAX)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_lcd_req(i_lcd_req), .i_lcd_data(i_lcd_data), .o_lcd_ack(o_lcd_ack),
    .i_sw_req(i_sw_req), .i_sw_data(i_sw_data), .o_sw_ack(o_sw_ack),
    .o_rdata(o_rdata), .o_spi_start(o_spi_start), .o_mosi_data(o_mosi_data),
    .i_spi_cs(i_spi_cs), .i_miso_data(i_miso_data),
    .o_lcd_cs(o_lcd_cs), .o_sw_cs(o_sw_cs), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // SPI master model and observation state
  int            cyc = 0;
  bit            m_hang = 0;
  int            m_dly = 0, m_hold = 1, m_phase = 0, m_cnt = 0, cyc_rel = 0;
  logic [DW-1:0] m_miso = '0;
  bit            t_start, t_lack, t_sack, t_err;
  int            n_start = 0, n_lack = 0, n_sack = 0, n_err = 0;
  // arbitration model
  bit            in_xfer = 0, exp_lcd = 0;
  int            streak = 0;
  int            exp_start = 0, exp_acks = 0;
  logic [DW-1:0] last_rdata = '0;
  bit            glog[$];

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    t_start = o_spi_start; t_lack = o_lcd_ack; t_sack = o_sw_ack; t_err = o_timeout_err;
    if (t_start) n_start++;
    if (t_lack) n_lack++;
    if (t_sack) n_sack++;
    if (t_err) n_err++;
    check("lcd_cs", 32'(o_lcd_cs), (in_xfer && exp_lcd && !i_spi_cs) ? 32'd0 : 32'd1);
    check("sw_cs", 32'(o_sw_cs), (in_xfer && !exp_lcd && !i_spi_cs) ? 32'd0 : 32'd1);
    if (t_lack || t_sack || t_err) in_xfer = 0;
    if (t_start) in_xfer = 1;
    case (m_phase)
      0: if (t_start && !m_hang) begin m_phase = 1; m_cnt = m_dly; end
      1: if (m_cnt == 0) begin i_spi_cs = 1'b0; m_phase = 2; m_cnt = m_hold - 1; end
         else m_cnt--;
      default: if (m_cnt == 0) begin
                 i_spi_cs = 1'b1; i_miso_data = m_miso; m_phase = 0; cyc_rel = cyc;
               end else m_cnt--;
    endcase
  endtask

  // One arbitrated transfer from the currently driven requests.
  task automatic xfer(input bit exp_err);
    bit            pl;
    logic [DW-1:0] pdata;
    int            k;
    int            c_start;
    pl = !(i_sw_req && !(i_lcd_req && streak == SMAX));
    if (pl) streak = 0;
    else streak = i_lcd_req ? streak + 1 : 0;
    exp_lcd = pl;
    pdata = pl ? i_lcd_data : i_sw_data;
    exp_start++;
    k = 0;
    do begin tick(); k++; end while (!t_start && k < 60);
    check("start_seen", 32'(t_start), 32'd1);
    if (!t_start) return;
    check("mosi", 32'(o_mosi_data), 32'(pdata));
    check("busy", 32'(o_busy), 32'd1);
    c_start = cyc;
    k = 0;
    do begin tick(); k++; end while (!(t_lack || t_sack || t_err) && k < 200);
    check("end_seen", 32'(t_lack || t_sack || t_err), 32'd1);
    if (exp_err) begin
      check("err", 32'(t_err), 32'd1);
      check("err_lat", 32'(cyc - c_start), 32'(TO + 1));
      check("err_noack", 32'(t_lack | t_sack), 32'd0);
      check("rdata_hold", 32'(o_rdata), 32'(last_rdata));
    end else begin
      exp_acks++;
      last_rdata = m_miso;
      check("no_err", 32'(t_err), 32'd0);
      check("lcd_ack", 32'(t_lack), 32'(pl));
      check("sw_ack", 32'(t_sack), 32'(!pl));
      check("rdata", 32'(o_rdata), 32'(m_miso));
      check("ack_lat", 32'(cyc - cyc_rel), 32'd1);
      glog.push_back(t_lack);
    end
  endtask

  initial begin
    bit exp_ord[6];
    int k;
    int acks0;
    int r;
    exp_ord = '{0, 0, 0, 0, 1, 0};

    repeat (3) tick();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_start", 32'(o_spi_start), 32'd0);
    check("rst_mosi", 32'(o_mosi_data), 32'd0);
    check("rst_rdata", 32'(o_rdata), 32'd0);
    check("rst_acks", 32'({o_lcd_ack, o_sw_ack, o_timeout_err}), 32'd0);
    i_rst = 1'b1;
    tick();

    // LCD only
    i_lcd_data = 24'hA51234; i_lcd_req = 1'b1;
    m_dly = 3; m_hold = 24; m_miso = 24'h5A5A01;
    xfer(0);
    i_lcd_req = 1'b0;
    repeat (5) tick();
    check("lcd_only_starts", 32'(n_start), 32'd1);
    check("lcd_only_acks", 32'(n_lack), 32'd1);

    // SW only
    streak = 0;
    i_sw_data = 24'h800001; i_sw_req = 1'b1;
    m_dly = 1; m_hold = 8; m_miso = 24'h00003C;
    xfer(0);
    i_sw_req = 1'b0;
    repeat (3) tick();
    check("sw_only_rdata", 32'(o_rdata), 32'h00003C);

    // Both held: bounded SW streak
    streak = 0;
    i_lcd_data = 24'h111111; i_sw_data = 24'h222222;
    i_lcd_req = 1'b1; i_sw_req = 1'b1;
    glog.delete();
    for (int i = 0; i < 6; i++) begin
      m_dly = i % 3; m_hold = 2 + i; m_miso = DW'($urandom);
      xfer(0);
    end
    for (int i = 0; i < 6; i++)
      check("grant_order", (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF, 32'(exp_ord[i]));
    i_lcd_req = 1'b0; i_sw_req = 1'b0; streak = 0;
    repeat (3) tick();

    // Hung master -> timeout, then retry by arbitration
    i_lcd_data = 24'h0F0F0F; i_lcd_req = 1'b1;
    m_hang = 1;
    xfer(1);
    m_hang = 0; m_dly = 0; m_hold = 3; m_miso = 24'hC0FFEE;
    xfer(0);
    i_lcd_req = 1'b0;
    repeat (3) tick();
    check("timeout_count", 32'(n_err), 32'd1);

    // Reset during WAIT_RELEASE
    streak = 0; exp_lcd = 1;
    i_lcd_data = 24'h777777; i_lcd_req = 1'b1;
    m_dly = 1; m_hold = 20; m_miso = 24'h123456;
    exp_start++;
    k = 0;
    do begin tick(); k++; end while (i_spi_cs && k < 40);
    check("rst_test_cs_low", 32'(i_spi_cs), 32'd0);
    repeat (3) tick();
    acks0 = n_lack + n_sack;
    i_rst = 1'b0;
    #1;
    in_xfer = 0; i_lcd_req = 1'b0; last_rdata = '0;
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_outs", 32'({o_spi_start, o_lcd_ack, o_sw_ack, o_timeout_err}), 32'd0);
    check("mid_rst_cs", 32'({o_lcd_cs, o_sw_cs}), 32'd3);
    check("mid_rst_mosi", 32'(o_mosi_data), 32'd0);
    check("mid_rst_rdata", 32'(o_rdata), 32'd0);
    repeat (3) tick();
    i_rst = 1'b1;
    repeat (40) tick();
    check("mid_rst_noack", 32'(n_lack + n_sack), 32'(acks0));

    // Request held one cycle past ack -> same data twice
    streak = 0;
    i_sw_data = 24'h3C3C3C; i_sw_req = 1'b1;
    m_dly = 2; m_hold = 5; m_miso = 24'h0000AA;
    acks0 = n_sack;
    xfer(0);
    m_miso = 24'h0000BB;
    xfer(0);
    i_sw_req = 1'b0;
    repeat (3) tick();
    check("held_two_acks", 32'(n_sack - acks0), 32'd2);

    // Randomized traffic
    streak = 0;
    for (int it = 0; it < 80; it++) begin
      if (!i_lcd_req && !i_sw_req) begin
        streak = 0;
        repeat ($urandom_range(0, 3)) tick();
        r = $urandom_range(1, 3);
        if (r[0]) begin i_lcd_data = DW'($urandom); i_lcd_req = 1'b1; end
        if (r[1]) begin i_sw_data = DW'($urandom); i_sw_req = 1'b1; end
      end
      m_dly = $urandom_range(0, 5); m_hold = $urandom_range(1, 24); m_miso = DW'($urandom);
      xfer(0);
      if (exp_lcd) begin
        i_lcd_req = 1'($urandom_range(0, 1));
        if (!i_sw_req && $urandom_range(0, 1) == 1) begin i_sw_data = DW'($urandom); i_sw_req = 1'b1; end
      end else begin
        i_sw_req = 1'($urandom_range(0, 1));
        if (!i_lcd_req && $urandom_range(0, 1) == 1) begin i_lcd_data = DW'($urandom); i_lcd_req = 1'b1; end
      end
    end
    i_lcd_req = 1'b0; i_sw_req = 1'b0;
    repeat (40) tick();
    check("total_starts", 32'(n_start), 32'(exp_start));
    check("total_acks", 32'(n_lack + n_sack), 32'(exp_acks));
    check("total_errs", 32'(n_err), 32'd1);
    check("idle_busy", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
